vga_text_term: RTL and testbench
================================

# vga_text_term

Text-mode terminal between a character source (keyboard decoder, CPU MMIO store) and the VGA scan-out. Accepts ASCII bytes over a valid/ready handshake and maintains a 70x30 character buffer with cursor, line wrap, backspace and hardware scroll. For each scanned pixel, it drives the glyph lookup (`font_ascii`/`font_row`/`font_col`), consumes the returned glyph bit, and emits 24-bit pixel colour.

## Interface
- `COLS`, 70: character columns.
- `ROWS`, 30: character rows.
- `CHAR_W`, 9: glyph width in pixels; only cols 0..8 of the glyph are used.
- `CHAR_H`, 16: glyph height in pixels.
- `FG`, 24'hFFFFFF: foreground colour.
- `BG`, 24'h000000: background colour.
- `clk`  in  1  single clock for everything.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wr_valid`  in  1  `wr_char` is offered.
- `wr_ready`  out  1  byte is accepted this cycle when `wr_valid` and `wr_ready` are both high.
- `wr_char`  in  8  ASCII byte.
- `h_addr`  in  10  current pixel column from the VGA timing generator.
- `v_addr`  in  10  current pixel row from the VGA timing generator.
- `vis`  in  1  `h_addr`/`v_addr` lie in the 640x480 visible area.
- `font_ascii`  out  8  glyph code to the font lookup.
- `font_row`  out  4  glyph pixel row.
- `font_col`  out  4  glyph pixel column.
- `font_bit`  in  1  glyph pixel; combinational, same cycle as the outputs above.
- `vga_data`  out  24  pixel colour.
- `vga_vis`  out  1  `vis` delayed to align with `vga_data`.

## Operation
- Buffer: ROWS*COLS bytes. Physical address = ((top + r) mod ROWS)*COLS + c. `top` is the scroll base row.
- Write FSM states: CLR_ALL, IDLE, CLR_LINE.
  - CLR_ALL (entered on reset): writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, then goes to IDLE.
  - CLR_LINE: writes 0x20 across the COLS cells of one physical row, then goes to IDLE.
  - `wr_ready` is 1 only in IDLE.
- Accepted byte handling:
  - 0x20..0x7E: store at cursor (r,c), then c++. If c reaches COLS: c=0, newline.
  - 0x0A: c=0, newline.
  - 0x0D: c=0.
  - 0x08: if c>0, c-- and store 0x20 at the new position. Else if r>0, r-- and c=COLS-1 and store 0x20. At (0,0) no effect.
  - Any other byte: accepted, no effect.
- Newline:
  - If r<ROWS-1: r++.
  - Else: top=(top+1) mod ROWS, the cursor stays on the last row, and CLR_LINE clears physical row old-top (the new bottom line).
- Render, per pixel:
  - Cell coordinates: cc=h_addr/CHAR_W, x=h_addr%CHAR_W, cr=v_addr/CHAR_H, y=v_addr%CHAR_H.
  - Pixels with cc>=COLS (h 630..639) or cr>=ROWS are blank and produce BG.
  - Otherwise the pixel is FG if `font_bit` else BG, inverted when (cr,cc) is the cursor cell.
  - `vis`=0 forces `vga_data`=0.
- Divide by 9 is a constant divide; no `$display` or file I/O in synthesizable code.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - `wr_ready`=0, `vga_data`=0, `vga_vis`=0, `font_*`=0.
  - cursor=(0,0), top=0, FSM=CLR_ALL.
  - Reset mid-clear or mid-write restarts CLR_ALL; partial state is discarded.
- `wr_ready` rises 2100 cycles (ROWS*COLS) after reset release.
- Character write latency: the buffer write happens in the acceptance cycle. The cursor update is visible the next cycle.
- Scroll: newline on the last row drops `wr_ready` for exactly COLS (70) cycles, starting the cycle after acceptance.
- Render pipeline, 3 cycles from inputs to output:
  - S1 registers cc/cr/x/y/blank/vis.
  - S2 issues the synchronous buffer read.
  - S3 drives `font_*` from the read data and delayed x/y, samples `font_bit`, and registers `vga_data`/`vga_vis`.
  - Inputs at cycle N appear on `vga_data` at N+3.
  - One pixel per cycle; no stalls.
- Simultaneous write and read of the same cell: the read returns the old value (read-first).
- Cursor and `top` used for rendering are sampled in S1; a scroll mid-frame tears by at most one pixel row, which is acceptable.

## Structure
- Package `vga_text_pkg`:
  - COLS, ROWS, CHAR_W, CHAR_H.
  - The FSM state enum {CLR_ALL, IDLE, CLR_LINE}.
  - Control codes CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_SP=8'h20.
- Sub-module `text_ram`: 1W/1R synchronous-read dual-port RAM, ROWS*COLS x 8, read-first.
- The font lookup stays external.

## Test plan
- Reset, hold `wr_valid`=1 with 'A' -> `wr_ready` low for 2100 cycles. 'A' is accepted on cycle 2101. Cell (0,0) renders 'A' glyph pixels, with glyph (0x41, y, x) requested at the cell's pixels.
- Send 70 x 'B' -> cursor wraps to (1,0). Pixel h=630..639 gives BG. `vga_data` equals the expected colour exactly 3 cycles after `h_addr`.
- Send "X", 0x08 at (0,1) -> cursor (0,0), cell holds 0x20. A further 0x08 at (0,0) leaves the state unchanged.
- Send 29 x 0x0A then 'Z', 0x0A -> `top`=1, `wr_ready` low for 70 cycles. The screen's last row is blank and 'Z' appears on row 28.
- Cursor cell with space -> FG fill across all 9x16 pixels. With `vis`=0 -> `vga_data`=0 and `vga_vis`=0.
- Assert `rst_n`=0 during CLR_LINE -> the next cycle has `wr_ready`=0, cursor (0,0), `top`=0, and CLR_ALL restarts.

Source files
------------

// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared geometry, write FSM states and control codes for vga_text_term
package vga_text_pkg;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 9;
  localparam int CHAR_H = 16;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_LINE
  } wr_state_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;

endpackage

// File: rtl/vga_text_term_text_ram.sv
// rtl/vga_text_term_text_ram.sv - character buffer, one write port and one synchronous read port
// Ports:
//   clk            single clock
//   we/waddr/wdata write port, written at the clock edge
//   raddr/rdata    read port, rdata valid the cycle after raddr; a same-cell
//                  write in that cycle is not seen (read-first)
module text_ram #(
  parameter int DEPTH = 2100,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_term.sv
// rtl/vga_text_term.sv - text-mode terminal: character writer with scroll plus 3-stage VGA renderer
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_char      ASCII byte input handshake
//   h_addr/v_addr/vis              pixel position from the VGA timing generator
//   font_ascii/font_row/font_col   glyph lookup request; font_bit is the same-cycle answer
//   vga_data/vga_vis               pixel colour and visibility, 3 cycles after h_addr/v_addr/vis
module vga_text_term #(
  parameter int          COLS   = vga_text_pkg::COLS,
  parameter int          ROWS   = vga_text_pkg::ROWS,
  parameter int          CHAR_W = vga_text_pkg::CHAR_W,
  parameter int          CHAR_H = vga_text_pkg::CHAR_H,
  parameter logic [23:0] FG     = 24'hFFFFFF,
  parameter logic [23:0] BG     = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_char,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        vis,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [3:0]  font_col,
  input  logic        font_bit,
  output logic [23:0] vga_data,
  output logic        vga_vis
);

  import vga_text_pkg::*;

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  // Logical row plus scroll base, folded back into 0..ROWS-1.
  function automatic logic [RW-1:0] wrap_row(input logic [RW-1:0] base, input logic [RW-1:0] off);
    logic [RW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= (RW+1)'(ROWS)) ? RW'(sum - (RW+1)'(ROWS)) : RW'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  // ---------------- write side ----------------
  wr_state_t     state;
  logic [RW-1:0] cur_r, top;
  logic [CW-1:0] cur_c;
  logic [AW-1:0] clr_addr;
  logic [CW-1:0] clr_cnt;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;

  logic          accept, is_print, do_nl;
  logic [RW-1:0] cur_prow;

  assign wr_ready = (state == IDLE);
  assign accept   = wr_valid && wr_ready;
  assign is_print = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign do_nl    = accept && ((is_print && cur_c == CW'(COLS-1)) || wr_char == CH_LF);
  assign cur_prow = wrap_row(top, cur_r);

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = CH_SP;
    case (state)
      CLR_ALL, CLR_LINE: we = 1'b1;
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            we    = 1'b1;
            waddr = cell_addr(cur_prow, cur_c);
            wdata = wr_char;
          end else if (wr_char == CH_BS && cur_c != '0) begin
            we    = 1'b1;
            waddr = cell_addr(cur_prow, cur_c - 1'b1);
          end else if (wr_char == CH_BS && cur_r != '0) begin
            we    = 1'b1;
            waddr = cell_addr(wrap_row(top, cur_r - 1'b1), CW'(COLS-1));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLR_ALL;
      cur_r    <= '0;
      cur_c    <= '0;
      top      <= '0;
      clr_addr <= '0;
      clr_cnt  <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_addr == AW'(CELLS-1)) state <= IDLE;
          else                          clr_addr <= clr_addr + 1'b1;
        end
        CLR_LINE: begin
          clr_addr <= clr_addr + 1'b1;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == CW'(COLS-1)) state <= IDLE;
        end
        IDLE: begin
          if (do_nl) begin
            cur_c <= '0;
            if (cur_r != RW'(ROWS-1)) begin
              cur_r <= cur_r + 1'b1;
            end else begin
              // Old top row becomes the new bottom line and must be blanked.
              top      <= (top == RW'(ROWS-1)) ? '0 : top + 1'b1;
              clr_addr <= cell_addr(top, '0);
              clr_cnt  <= '0;
              state    <= CLR_LINE;
            end
          end else if (accept) begin
            if (is_print) begin
              cur_c <= cur_c + 1'b1;
            end else if (wr_char == CH_CR) begin
              cur_c <= '0;
            end else if (wr_char == CH_BS) begin
              if (cur_c != '0) begin
                cur_c <= cur_c - 1'b1;
              end else if (cur_r != '0) begin
                cur_r <= cur_r - 1'b1;
                cur_c <= CW'(COLS-1);
              end
            end
          end
        end
        default: state <= CLR_ALL;
      endcase
    end
  end

  text_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // ---------------- render pipeline ----------------
  logic [9:0]    cc_n, cr_n;
  logic [9:0]    cc1, cr1;
  logic [3:0]    x1, y1, x2, y2;
  logic          blank1, vis1, cur1;
  logic          blank2, vis2, cur2, live2;
  logic [RW-1:0] top1;
  logic          pix;

  assign cc_n = h_addr / 10'(CHAR_W);
  assign cr_n = v_addr / 10'(CHAR_H);

  // Blank cells may index past the buffer, so they read address 0 instead.
  assign raddr = blank1 ? '0 : cell_addr(wrap_row(top1, RW'(cr1)), CW'(cc1));

  assign font_ascii = live2 ? rdata : 8'h00;
  assign font_row   = y2;
  assign font_col   = x2;
  assign pix        = !blank2 && (font_bit ^ cur2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc1      <= '0;
      cr1      <= '0;
      x1       <= '0;
      y1       <= '0;
      blank1   <= 1'b0;
      vis1     <= 1'b0;
      cur1     <= 1'b0;
      top1     <= '0;
      x2       <= '0;
      y2       <= '0;
      blank2   <= 1'b0;
      vis2     <= 1'b0;
      cur2     <= 1'b0;
      live2    <= 1'b0;
      vga_data <= '0;
      vga_vis  <= 1'b0;
    end else begin
      cc1      <= cc_n;
      cr1      <= cr_n;
      x1       <= 4'(h_addr % 10'(CHAR_W));
      y1       <= 4'(v_addr % 10'(CHAR_H));
      blank1   <= (cc_n >= 10'(COLS)) || (cr_n >= 10'(ROWS));
      vis1     <= vis;
      cur1     <= (cc_n == 10'(cur_c)) && (cr_n == 10'(cur_r));
      top1     <= top;
      x2       <= x1;
      y2       <= y1;
      blank2   <= blank1;
      vis2     <= vis1;
      cur2     <= cur1;
      live2    <= vis1 && !blank1;
      vga_data <= !vis2 ? 24'h000000 : (pix ? FG : BG);
      vga_vis  <= vis2;
    end
  end

endmodule

// File: tb/tb_vga_text_term.sv
// tb/tb_vga_text_term.sv - self-checking bench for vga_text_term against a logical-screen model
module tb_vga_text_term;
  import vga_text_pkg::*;

  localparam logic [23:0] FG_C = 24'hFFFFFF;
  localparam logic [23:0] BG_C = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n, wr_valid, wr_ready, vis, font_bit, vga_vis;
  logic [7:0]  wr_char, font_ascii;
  logic [9:0]  h_addr, v_addr;
  logic [3:0]  font_row, font_col;
  logic [23:0] vga_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Logical screen: row 0 is the top visible line, independent of any scroll base.
  logic [7:0] scr [ROWS][COLS];
  int mr, mc;

  typedef struct {int h; int v; bit vis;} pix_t;
  pix_t pix_q[$];

  vga_text_term #(.FG(FG_C), .BG(BG_C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_char    (wr_char),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .vis        (vis),
    .font_ascii (font_ascii),
    .font_row   (font_row),
    .font_col   (font_col),
    .font_bit   (font_bit),
    .vga_data   (vga_data),
    .vga_vis    (vga_vis)
  );

  always #5 clk = ~clk;

  // Stand-in font ROM: space is empty, other glyphs get an arbitrary pattern.
  function automatic logic glyph(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
    if (a == 8'h20) return 1'b0;
    return ((int'(a) + 5 * int'(r) + 7 * int'(c)) % 4) == 0;
  endfunction

  assign font_bit = glyph(font_ascii, font_row, font_col);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = 8'h20;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_nl();
    if (mr < ROWS - 1) begin
      mr++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = 8'h20;
    end
  endtask

  task automatic model_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[mr][mc] = ch;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        model_nl();
      end
    end else if (ch == 8'h0A) begin
      mc = 0;
      model_nl();
    end else if (ch == 8'h0D) begin
      mc = 0;
    end else if (ch == 8'h08) begin
      if (mc > 0) begin
        mc--;
        scr[mr][mc] = 8'h20;
      end else if (mr > 0) begin
        mr--;
        mc = COLS - 1;
        scr[mr][mc] = 8'h20;
      end
    end
  endtask

  task automatic count_busy(input int limit, output int n);
    n = 0;
    while (!wr_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_char  = ch;
    count_busy(5000, n);
    check("send_ready", {31'b0, wr_ready}, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    model_apply(ch);
  endtask

  task automatic queue_cell(input int cr, input int cc, input bit v);
    for (int y = 0; y < CHAR_H; y++)
      for (int x = 0; x < CHAR_W; x++)
        pix_q.push_back('{h: cc * CHAR_W + x, v: cr * CHAR_H + y, vis: v});
  endtask

  task automatic queue_strip(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++)
      pix_q.push_back('{h: h, v: v, vis: 1'b1});
  endtask

  task automatic queue_random(input int n);
    for (int i = 0; i < n; i++)
      pix_q.push_back('{h: int'($urandom_range(639, 0)), v: int'($urandom_range(479, 0)),
                        vis: ($urandom_range(7, 0) != 0)});
  endtask

  function automatic bit in_text(input pix_t p);
    return (p.h / CHAR_W < COLS) && (p.v / CHAR_H < ROWS);
  endfunction

  function automatic logic [23:0] exp_pix(input pix_t p);
    int cc, cr;
    logic b;
    if (!p.vis) return 24'h000000;
    if (!in_text(p)) return BG_C;
    cc = p.h / CHAR_W;
    cr = p.v / CHAR_H;
    b = glyph(scr[cr][cc], 4'(p.v % CHAR_H), 4'(p.h % CHAR_W)) ^ (cr == mr && cc == mc);
    return b ? FG_C : BG_C;
  endfunction

  function automatic logic [15:0] exp_font(input pix_t p);
    return {scr[p.v / CHAR_H][p.h / CHAR_W], 4'(p.v % CHAR_H), 4'(p.h % CHAR_W)};
  endfunction

  // Streams the queued pixels one per cycle; font request checked 2 cycles and
  // colour 3 cycles after each pixel is presented.
  task automatic render_run();
    pix_t p[$];
    int n;
    p = pix_q;
    pix_q.delete();
    n = p.size();
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check("vga_data", {8'h0, vga_data}, {8'h0, exp_pix(p[k-3])});
        check("vga_vis", {31'b0, vga_vis}, {31'b0, p[k-3].vis});
      end
      if (k >= 2 && k - 2 < n) begin
        if (p[k-2].vis && in_text(p[k-2]))
          check("font_req", {16'h0, font_ascii, font_row, font_col}, {16'h0, exp_font(p[k-2])});
      end
      if (k < n) begin
        h_addr = 10'(p[k].h);
        v_addr = 10'(p[k].v);
        vis    = p[k].vis;
      end else begin
        vis = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    logic [7:0] ch;

    rst_n = 1'b0; wr_valid = 1'b0; wr_char = 8'h00;
    h_addr = '0; v_addr = '0; vis = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_vga_data", {8'h0, vga_data}, 32'd0);
    check("rst_vga_vis", {31'b0, vga_vis}, 32'd0);
    check("rst_font", {16'h0, font_ascii, font_row, font_col}, 32'd0);

    // Clear after reset: 'A' offered throughout, taken once the clear finishes.
    model_reset();
    wr_valid = 1'b1;
    wr_char  = 8'h41;
    rst_n    = 1'b1;
    count_busy(5000, n);
    check("init_busy_cycles", n, 32'd2100);
    @(negedge clk);
    wr_valid = 1'b0;
    model_apply(8'h41);
    queue_cell(0, 0, 1'b1);
    queue_cell(0, 1, 1'b1);
    render_run();

    // Full row of 'B' wraps the cursor; right margin stays blank.
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h42);
    queue_cell(1, 0, 1'b1);
    queue_strip(5, 600, 639);
    queue_random(150);
    render_run();

    // Backspace across the row boundary, then within a row, then at home.
    send(8'h08);
    send(8'h0D);
    send(8'h58);
    send(8'h08);
    send(8'h08);
    queue_cell(0, 0, 1'b1);
    queue_cell(0, 1, 1'b1);
    queue_cell(0, 69, 1'b1);
    queue_random(100);
    render_run();

    // Walk to the last row and scroll once.
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    send(8'h5A);
    send(8'h0A);
    count_busy(500, n);
    check("scroll_busy_cycles", n, 32'd70);
    queue_cell(28, 0, 1'b1);
    queue_cell(29, 0, 1'b1);
    queue_cell(29, 1, 1'b1);
    queue_strip(470, 0, 639);
    queue_cell(29, 0, 1'b0);
    queue_random(100);
    render_run();

    // Random byte stream mixing printable and control codes.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(9, 0))
        0: ch = 8'h0A;
        1: ch = 8'h08;
        2: ch = 8'h0D;
        3: ch = 8'($urandom_range(31, 0)) | 8'h80;
        default: ch = 8'($urandom_range(126, 32));
      endcase
      send(ch);
    end
    queue_cell(mr, mc, 1'b1);
    queue_random(300);
    render_run();

    // Reset while a line clear is in progress.
    for (int i = 0; i < ROWS; i++) send(8'h0A);
    repeat (5) @(negedge clk);
    check("clr_line_busy", {31'b0, wr_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("midclr_rst_vga_vis", {31'b0, vga_vis}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    count_busy(5000, n);
    check("reclear_busy_cycles", n, 32'd2100);
    send(8'h51);
    queue_cell(0, 0, 1'b1);
    queue_cell(0, 1, 1'b1);
    queue_random(150);
    render_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
